// File: rtl/boreal_mem_pkg.sv
// boreal_mem_pkg: shared state encoding, owner ids and default widths for the port-B arbiter
package boreal_mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_LRN = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_RESP} state_t;
endpackage

// File: rtl/boreal_rr_arb2.sv
// boreal_rr_arb2: two-input round-robin selector; the requester not granted last wins a tie
module boreal_rr_arb2 import boreal_mem_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt[OWN_HOST] = req[OWN_HOST] & (~req[OWN_LRN] | (last == OWN_LRN));
  assign gnt[OWN_LRN]  = req[OWN_LRN] & (~req[OWN_HOST] | (last == OWN_HOST));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= OWN_LRN;
    else if (en && |req) last <= gnt[OWN_LRN];
endmodule

// File: rtl/boreal_mem_arbiter.sv
// boreal_mem_arbiter: shares memory port B between host and learning engine, one read-first access per request
module boreal_mem_arbiter import boreal_mem_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_we,
  input  logic [ADDR_WIDTH-1:0] host_req_addr,
  input  logic [DATA_WIDTH-1:0] host_req_wdata,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DATA_WIDTH-1:0] host_rsp_rdata,
  input  logic                  lrn_req_valid,
  output logic                  lrn_req_ready,
  input  logic                  lrn_req_we,
  input  logic [ADDR_WIDTH-1:0] lrn_req_addr,
  input  logic [DATA_WIDTH-1:0] lrn_req_wdata,
  output logic                  lrn_rsp_valid,
  input  logic                  lrn_rsp_ready,
  output logic [DATA_WIDTH-1:0] lrn_rsp_rdata,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_din_b,
  input  logic [DATA_WIDTH-1:0] mem_dout_b,
  output logic                  busy,
  output logic                  grant_lrn
);
  state_t state, nxt;
  logic [1:0] gnt;
  logic idle, acc, rsp_done;
  assign idle = state == ST_IDLE;
  boreal_rr_arb2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .en(idle),
    .req({lrn_req_valid, host_req_valid}),
    .gnt(gnt)
  );
  assign host_req_ready = idle & gnt[OWN_HOST];
  assign lrn_req_ready  = idle & gnt[OWN_LRN];
  assign acc = host_req_ready | lrn_req_ready;
  assign rsp_done = (grant_lrn == OWN_LRN) ? lrn_rsp_ready : host_rsp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = idle ? (acc ? ST_ACCESS : ST_IDLE) :
          state == ST_ACCESS  ? ST_CAPTURE :
          state == ST_CAPTURE ? ST_RESP :
          rsp_done ? ST_IDLE : ST_RESP;
  end
  // The mem_* registers double as the request latch: loaded on accept, they are live during ACCESS.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we_b       <= 1'b0;
      mem_addr_b     <= '0;
      mem_din_b      <= '0;
      grant_lrn      <= 1'b0;
      busy           <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= '0;
      lrn_rsp_valid  <= 1'b0;
      lrn_rsp_rdata  <= '0;
    end else begin
      busy     <= nxt != ST_IDLE;
      mem_we_b <= acc & (gnt[OWN_LRN] ? lrn_req_we : host_req_we);
      if (acc) begin
        grant_lrn  <= gnt[OWN_LRN];
        mem_addr_b <= gnt[OWN_LRN] ? lrn_req_addr : host_req_addr;
        mem_din_b  <= gnt[OWN_LRN] ? lrn_req_wdata : host_req_wdata;
      end
      if (state == ST_CAPTURE) begin
        if (grant_lrn == OWN_LRN) begin
          lrn_rsp_valid <= 1'b1;
          lrn_rsp_rdata <= mem_dout_b;
        end else begin
          host_rsp_valid <= 1'b1;
          host_rsp_rdata <= mem_dout_b;
        end
      end
      if (state == ST_RESP && rsp_done) begin
        host_rsp_valid <= 1'b0;
        lrn_rsp_valid  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_boreal_mem_arbiter.sv
// tb_boreal_mem_arbiter: scenario tasks with a response scoreboard and a read-first memory model on port B
module tb_boreal_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  typedef struct packed {logic own; logic [DW-1:0] data;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic host_req_valid, host_req_ready, host_req_we, host_rsp_valid, host_rsp_ready;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata, host_rsp_rdata;
  logic lrn_req_valid, lrn_req_ready, lrn_req_we, lrn_rsp_valid, lrn_rsp_ready;
  logic [AW-1:0] lrn_req_addr;
  logic [DW-1:0] lrn_req_wdata, lrn_rsp_rdata;
  logic mem_we_b, busy, grant_lrn;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_din_b, mem_dout_b;
  logic [112:0] all_out;

  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];

  always #5 clk = ~clk;

  boreal_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_we(host_req_we),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready), .host_rsp_rdata(host_rsp_rdata),
    .lrn_req_valid(lrn_req_valid), .lrn_req_ready(lrn_req_ready), .lrn_req_we(lrn_req_we),
    .lrn_req_addr(lrn_req_addr), .lrn_req_wdata(lrn_req_wdata),
    .lrn_rsp_valid(lrn_rsp_valid), .lrn_rsp_ready(lrn_rsp_ready), .lrn_rsp_rdata(lrn_rsp_rdata),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b), .mem_dout_b(mem_dout_b),
    .busy(busy), .grant_lrn(grant_lrn)
  );

  assign all_out = {mem_we_b, mem_addr_b, mem_din_b, host_rsp_valid, lrn_rsp_valid, host_rsp_rdata,
                    lrn_rsp_rdata, busy, grant_lrn, host_req_ready, lrn_req_ready};

  always @(posedge clk) begin
    mem_dout_b <= mem[mem_addr_b];
    if (mem_we_b) mem[mem_addr_b] <= mem_din_b;
  end

  task automatic push(input logic o, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    x.own = o;
    x.data = ref_mem[a];
    sb.push_back(x);
    if (we) ref_mem[a] = d;
  endtask

  task automatic pop(output exp_t e);
    e = sb.size() > 0 ? sb.pop_front() : '0;
  endtask

  task automatic set_host(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req_valid = v; host_req_we = we; host_req_addr = a; host_req_wdata = d;
  endtask

  task automatic set_lrn(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lrn_req_valid = v; lrn_req_we = we; lrn_req_addr = a; lrn_req_wdata = d;
  endtask

  task automatic wait_rsp(output logic ok, output logic own, output logic [DW-1:0] data, output int cyc);
    ok = 1'b0; own = 1'b0; data = '0; cyc = 0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk);
      if (host_rsp_valid || lrn_rsp_valid) begin
        ok = 1'b1;
        own = lrn_rsp_valid;
        data = lrn_rsp_valid ? lrn_rsp_rdata : host_rsp_rdata;
        cyc = i;
      end
    end
  endtask

  task automatic test_reset;
    set_host(0, 0, '0, '0);
    set_lrn(0, 0, '0, '0);
    host_rsp_ready = 1'b1;
    lrn_rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || host_req_ready !== 1'b0 || lrn_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b hrdy=%b lrdy=%b want 0 0 0", busy, host_req_ready, lrn_req_ready);
    end
  endtask

  task automatic test_host_write;
    exp_t e;
    @(negedge clk);
    set_host(1, 1, 10'h005, 32'hDEADBEEF);
    #1;
    n_chk++;
    if (host_req_ready !== 1'b1 || lrn_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL hw_ready: hrdy=%b lrdy=%b want 1 0", host_req_ready, lrn_req_ready);
    end
    push(0, 1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    host_req_valid = 1'b0;
    n_chk++;
    if (mem_we_b !== 1'b1 || mem_addr_b !== 10'h005 || mem_din_b !== 32'hDEADBEEF || busy !== 1'b1) begin
      n_fail++; $display("FAIL hw_access: we=%b addr=%h din=%h busy=%b want 1 005 deadbeef 1", mem_we_b, mem_addr_b, mem_din_b, busy);
    end
    @(negedge clk);
    n_chk++;
    if (mem_we_b !== 1'b0 || host_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hw_capture: we=%b rsp_valid=%b want 0 0", mem_we_b, host_rsp_valid);
    end
    @(negedge clk);
    pop(e);
    n_chk++;
    if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== e.data || lrn_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hw_rsp: valid=%b rdata=%h lvalid=%b want 1 %h 0", host_rsp_valid, host_rsp_rdata, lrn_rsp_valid, e.data);
    end
    @(negedge clk);
    n_chk++;
    if (host_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hw_done: valid=%b busy=%b want 0 0", host_rsp_valid, busy);
    end
  endtask

  task automatic test_host_read;
    exp_t e;
    logic ok, o;
    logic [DW-1:0] d;
    int c;
    set_host(1, 0, 10'h005, '0);
    #1;
    push(0, 0, 10'h005, '0);
    @(negedge clk);
    host_req_valid = 1'b0;
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data || c != 2 || lrn_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hr_rsp: ok=%b own=%b data=%h cyc=%0d lvalid=%b want own=%b data=%h cyc=2", ok, o, d, c, lrn_rsp_valid, e.own, e.data);
    end
  endtask

  task automatic test_round_robin;
    exp_t e;
    logic ok, o, w;
    logic [DW-1:0] d;
    int c, hi, li;
    logic h_we [2] = '{1'b1, 1'b0};
    @(negedge clk);
    set_lrn(1, 0, 10'h003, '0);
    #1;
    push(1, 0, 10'h003, '0);
    @(negedge clk);
    lrn_req_valid = 1'b0;
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data) begin
      n_fail++; $display("FAIL rr_single: ok=%b own=%b data=%h want own=%b data=%h", ok, o, d, e.own, e.data);
    end
    hi = 0; li = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      set_host(hi < 2, h_we[hi % 2], 10'h010, 32'hAAAA0001);
      set_lrn(li < 2, h_we[li % 2], 10'h020, 32'hBBBB0002);
      #1;
      w = t[0];
      n_chk++;
      if (host_req_ready !== ~w || lrn_req_ready !== w) begin
        n_fail++; $display("FAIL rr_grant%0d: hrdy=%b lrdy=%b want %b %b", t, host_req_ready, lrn_req_ready, ~w, w);
      end
      if (w) begin push(1, h_we[li % 2], 10'h020, 32'hBBBB0002); li++; end
      else begin push(0, h_we[hi % 2], 10'h010, 32'hAAAA0001); hi++; end
      wait_rsp(ok, o, d, c);
      pop(e);
      n_chk++;
      if (!ok || o !== e.own || d !== e.data) begin
        n_fail++; $display("FAIL rr_rsp%0d: ok=%b own=%b data=%h want own=%b data=%h", t, ok, o, d, e.own, e.data);
      end
    end
    host_req_valid = 1'b0;
    lrn_req_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic ok, o;
    logic [DW-1:0] d;
    int c;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    set_host(1, 0, 10'h020, '0);
    #1;
    push(0, 0, 10'h020, '0);
    @(negedge clk);
    host_req_valid = 1'b0;
    set_lrn(1, 0, 10'h010, '0);
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data) begin
      n_fail++; $display("FAIL bp_rsp: ok=%b own=%b data=%h want own=%b data=%h", ok, o, d, e.own, e.data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== e.data || busy !== 1'b1 || lrn_req_ready !== 1'b0 || lrn_rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b rdata=%h busy=%b lrdy=%b lvalid=%b want 1 %h 1 0 0", i, host_rsp_valid, host_rsp_rdata, busy, lrn_req_ready, lrn_rsp_valid, e.data);
      end
    end
    host_rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (host_rsp_valid !== 1'b0 || lrn_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: hvalid=%b lrdy=%b want 0 1", host_rsp_valid, lrn_req_ready);
    end
    push(1, 0, 10'h010, '0);
    @(negedge clk);
    lrn_req_valid = 1'b0;
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data) begin
      n_fail++; $display("FAIL bp_lrn_rsp: ok=%b own=%b data=%h want own=%b data=%h", ok, o, d, e.own, e.data);
    end
  endtask

  task automatic test_lrn_top;
    exp_t e;
    logic ok, o;
    logic [DW-1:0] d;
    int c;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_lrn(1, k == 0, 10'h3FF, 32'h12345678);
      #1;
      n_chk++;
      if (lrn_req_ready !== 1'b1) begin n_fail++; $display("FAIL lt_ready%0d: lrdy=%b want 1", k, lrn_req_ready); end
      push(1, k == 0, 10'h3FF, 32'h12345678);
      @(negedge clk);
      lrn_req_valid = 1'b0;
      n_chk++;
      if (mem_addr_b !== 10'h3FF || mem_we_b !== (k == 0) || grant_lrn !== 1'b1) begin
        n_fail++; $display("FAIL lt_access%0d: addr=%h we=%b grant=%b want 3ff %b 1", k, mem_addr_b, mem_we_b, grant_lrn, k == 0);
      end
      wait_rsp(ok, o, d, c);
      pop(e);
      n_chk++;
      if (!ok || o !== e.own || d !== e.data || c != 2 || host_rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL lt_rsp%0d: ok=%b own=%b data=%h cyc=%0d want own=%b data=%h cyc=2", k, ok, o, d, c, e.own, e.data);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic ok, o;
    logic [DW-1:0] d;
    int c;
    @(negedge clk);
    set_host(1, 0, 10'h005, '0);
    #1;
    push(0, 0, 10'h005, '0);
    @(negedge clk);
    host_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (all_out !== '0) begin n_fail++; $display("FAIL rm_async: got %h want 0", all_out); end
    pop(e);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_host(1, 0, 10'h010, '0);
    set_lrn(1, 0, 10'h020, '0);
    #1;
    n_chk++;
    if (host_req_ready !== 1'b1 || lrn_req_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_tie: hrdy=%b lrdy=%b busy=%b want 1 0 0", host_req_ready, lrn_req_ready, busy);
    end
    push(0, 0, 10'h010, '0);
    @(negedge clk);
    host_req_valid = 1'b0;
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data) begin
      n_fail++; $display("FAIL rm_host_rsp: ok=%b own=%b data=%h want own=%b data=%h", ok, o, d, e.own, e.data);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (lrn_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_lrn_ready: lrdy=%b want 1", lrn_req_ready); end
    push(1, 0, 10'h020, '0);
    @(negedge clk);
    lrn_req_valid = 1'b0;
    wait_rsp(ok, o, d, c);
    pop(e);
    n_chk++;
    if (!ok || o !== e.own || d !== e.data) begin
      n_fail++; $display("FAIL rm_lrn_rsp: ok=%b own=%b data=%h want own=%b data=%h", ok, o, d, e.own, e.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset;
    test_host_write;
    test_host_read;
    test_round_robin;
    test_backpressure;
    test_lrn_top;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/boreal_mem_arbiter.md
Name: boreal_mem_arbiter

Overview:
Port-B controller for the Boreal weight/LUT memory. It shares the single read/write port between two requesters: the host/UART update path and the on-chip learning engine. Each accepted request becomes one memory access with a fixed sequence and a response. Writes return the previous word (read-first), so read-modify-write visibility is atomic per request. Port A (inference) is untouched.

Parameters:
ADDR_WIDTH, 10, memory word-address width
DATA_WIDTH, 32, memory word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_req_valid  in  1  host request present
host_req_ready  out  1  host request accepted this cycle when valid&ready
host_req_we  in  1  1=write, 0=read
host_req_addr  in  ADDR_WIDTH  word address
host_req_wdata  in  DATA_WIDTH  write data
host_rsp_valid  out  1  host response available
host_rsp_ready  in  1  host consumes response
host_rsp_rdata  out  DATA_WIDTH  read data (for writes: prior contents)
lrn_req_valid / lrn_req_ready / lrn_req_we / lrn_req_addr / lrn_req_wdata  same as host_*, learning engine
lrn_rsp_valid / lrn_rsp_ready / lrn_rsp_rdata  same as host_*, learning engine
mem_we_b  out  1  memory port-B write enable
mem_addr_b  out  ADDR_WIDTH  memory port-B address
mem_din_b  out  DATA_WIDTH  memory port-B write data
mem_dout_b  in  DATA_WIDTH  memory port-B registered read data (1-cycle latency, read-first)
busy  out  1  state != IDLE
grant_lrn  out  1  owner of current/last transaction (0=host, 1=learning)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; last_grant=1, so the host wins the first tie.
- FSM states: IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE. Exactly one transaction is in flight; there is no pipelining.
- IDLE:
  - *_req_ready is combinational: asserted only in IDLE, and only toward the selected requester.
  - Selection: only one valid requester -> that one. Both valid -> round-robin (the requester not in last_grant).
  - On accept (valid&ready, cycle N): latch we/addr/wdata and owner; update last_grant; go to ACCESS.
  - The non-selected requester sees ready=0 and must hold its request stable.
- ACCESS (N+1):
  - mem_addr_b = latched addr.
  - mem_din_b = latched wdata.
  - mem_we_b = latched we, asserted for exactly this one cycle.
- CAPTURE (N+2):
  - mem_dout_b is valid. Register it into the owner's rsp_rdata.
  - Set the owner's rsp_valid (visible N+3). Go to RESP.
  - mem_we_b=0. mem_addr_b holds its value; don't-care.
- RESP:
  - Hold rsp_valid and rdata stable until rsp_ready.
  - On valid&ready, clear rsp_valid and go to IDLE.
  - Zero-wait throughput: one transaction per 4 cycles (accept to next accept).
- rsp_ready is ignored when the matching rsp_valid=0. The non-owner's rsp_valid is always 0.
- Registered outputs: mem_*, *_rsp_*, busy, grant_lrn. Only *_req_ready is combinational, from state, valid inputs and last_grant.
- Address and data pass through unchanged. No width conversion, no address range check: every address is 0..2^ADDR_WIDTH-1 by construction.
- Reset mid-transaction:
  - Asserting rst_n=0 during ACCESS drops mem_we_b immediately. Whether the write commits is undefined.
  - A pending response is discarded; the requester must reissue.
- Requests arriving during a busy state wait, with no loss and no reordering per requester.

Decomposition:
- Shared package boreal_mem_pkg: state encoding (ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_RESP), owner constants (OWN_HOST=0, OWN_LRN=1), and default ADDR_WIDTH/DATA_WIDTH.
- One natural sub-module: boreal_rr_arb2, a two-input round-robin selector holding last_grant and producing the one-hot grant. The FSM and datapath latch stay in the top block.

Test Plan:
1. Host write addr 0x005 data 0xDEADBEEF after reset (memory 0) -> mem_we_b high exactly at N+1 with addr 0x005; host_rsp_valid at N+3 with rdata 0x00000000.
2. Host read addr 0x005 -> host_rsp_rdata 0xDEADBEEF at N+3; lrn_rsp_valid stays 0.
3. Host and learning both valid in the same IDLE cycle, repeated 4 times -> grants alternate H, L, H, L; each response carries its own address's data.
4. Host holds host_rsp_ready=0 for 10 cycles -> rsp stable, busy=1, lrn request not accepted until the response is consumed.
5. Learning write 0x3FF (top address) 0x12345678, then read back -> 0x12345678; the write response returns the previous value.
6. rst_n pulled low during CAPTURE -> all outputs 0 asynchronously; after release, state is IDLE and the host wins the first tie.
